// File: rtl/pim_tile_engine_pkg.sv
// Shared types for the PIM tile engine: tile geometry, data word and engine state.
// Everything that must agree between controller and engine lives here.
package pim_tile_engine_pkg;

  localparam int WIDTH             = 16;
  localparam int CHUNK_SIZE        = 2;
  localparam int PIM_UNIT_CAPACITY = 2;

  // Keeps counters at least one bit wide when a dimension collapses to 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_W = idx_width(CHUNK_SIZE);
  localparam int K_W   = idx_width(PIM_UNIT_CAPACITY);
  localparam int RES_W = idx_width(CHUNK_SIZE * CHUNK_SIZE);

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } pim_eng_state_t;

endpackage

// File: rtl/pim_tile_engine_if.sv
// Controller <-> engine request/response bundle: operand tiles in, product tile out.
// The controller holds the master side, the engine the slave side.
interface pim_tile_engine_if;
  import pim_tile_engine_pkg::*;

  logic  valid;
  word_t matrixA [CHUNK_SIZE][PIM_UNIT_CAPACITY];
  word_t matrixB [PIM_UNIT_CAPACITY][CHUNK_SIZE];
  word_t result  [CHUNK_SIZE*CHUNK_SIZE];
  logic  result_valid;
  logic  busy;

  modport master (
    output valid, matrixA, matrixB,
    input  result, result_valid, busy
  );

  modport slave (
    input  valid, matrixA, matrixB,
    output result, result_valid, busy
  );

endinterface

// File: rtl/pim_tile_engine_mac.sv
// Single multiply-accumulate lane, modulo 2**WIDTH. acc presents the running sum
// including this cycle's product, so the caller can store a finished element directly.
module pim_mac
  import pim_tile_engine_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  word_t a,
  input  word_t b,
  input  logic  clear,
  input  logic  en,
  output word_t acc
);

  word_t acc_q;
  word_t product;

  assign product = a * b;
  assign acc     = acc_q + product;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc;
    end
  end

endmodule

// File: rtl/pim_tile_engine.sv
// Tile matrix-multiply engine: one MAC per cycle over k, then j, then i, with a
// fixed latency independent of operand values.
module pim_tile_engine
  import pim_tile_engine_pkg::*;
#(
  parameter int ID = 0
) (
  input logic              clk,
  input logic              rst,
  pim_tile_engine_if.slave bus
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(CHUNK_SIZE - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(PIM_UNIT_CAPACITY - 1);

  // ID only tags the instance for debug views; negative values have no meaning.
  if (ID < 0) begin : g_bad_id
  end

  pim_eng_state_t   state_q, state_d;
  logic [ROW_W-1:0] i_q, j_q;
  logic [K_W-1:0]   k_q;
  logic [RES_W-1:0] res_idx;
  logic             accept, mac_en, mac_clear;
  logic             i_last, j_last, k_last;
  word_t            mac_acc;

  word_t op_a     [CHUNK_SIZE][PIM_UNIT_CAPACITY];
  word_t op_b     [PIM_UNIT_CAPACITY][CHUNK_SIZE];
  word_t result_q [CHUNK_SIZE*CHUNK_SIZE];

  assign i_last  = (i_q == ROW_LAST);
  assign j_last  = (j_q == ROW_LAST);
  assign k_last  = (k_q == K_LAST);
  assign res_idx = RES_W'(int'(i_q) * CHUNK_SIZE + int'(j_q));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    mac_en    = 1'b0;
    mac_clear = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.valid) begin
          accept    = 1'b1;
          mac_clear = 1'b1;
          state_d   = COMPUTE;
        end else begin
          state_d   = IDLE;
        end
      end
      COMPUTE: begin
        mac_en    = 1'b1;
        mac_clear = k_last;
        if (i_last && j_last && k_last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: operand tiles are always loaded before they are read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= bus.matrixA;
      op_b <= bus.matrixB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      result_q <= '{default: '0};
    end else if (accept) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (mac_en) begin
      k_q <= k_last ? '0 : k_q + 1'b1;
      if (k_last) begin
        result_q[res_idx] <= mac_acc;
        j_q <= j_last ? '0 : j_q + 1'b1;
        if (j_last) i_q <= i_last ? '0 : i_q + 1'b1;
      end
    end
  end

  pim_mac u_mac (
    .clk   (clk),
    .rst   (rst),
    .a     (op_a[i_q][k_q]),
    .b     (op_b[k_q][j_q]),
    .clear (mac_clear),
    .en    (mac_en),
    .acc   (mac_acc)
  );

  assign bus.result       = result_q;
  assign bus.result_valid = (state_q == DONE);
  assign bus.busy         = (state_q == COMPUTE);

endmodule

// File: tb/tb_pim_tile_engine.sv
// Randomised bench for pim_tile_engine against a timeline/matrix-product reference model.
// Inputs change #1 after the rising edge; outputs are compared on the falling edge.
module tb_pim_tile_engine;
  import pim_tile_engine_pkg::*;

  localparam int N   = CHUNK_SIZE * CHUNK_SIZE * PIM_UNIT_CAPACITY;
  localparam int ELS = CHUNK_SIZE * CHUNK_SIZE;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pim_tile_engine_if bus ();

  pim_tile_engine #(.ID(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: cycle index, pending request and its expected product.
  int  t        = 0;
  bit  pend     = 1'b0;
  int  acc_t    = 0;
  bit  zero_chk = 1'b0;
  int  exp_res [ELS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, t, got, exp);
    else             n_pass++;
  endtask

  // Packed element e (row-major) sits at bits [e*16 +: 16]; bench runs the 2x2x2 configuration.
  task automatic load_ops(input logic [63:0] a, input logic [63:0] b);
    for (int r = 0; r < CHUNK_SIZE; r++)
      for (int c = 0; c < PIM_UNIT_CAPACITY; c++)
        bus.matrixA[r][c] = a[(r*PIM_UNIT_CAPACITY+c)*16 +: 16];
    for (int r = 0; r < PIM_UNIT_CAPACITY; r++)
      for (int c = 0; c < CHUNK_SIZE; c++)
        bus.matrixB[r][c] = b[(r*CHUNK_SIZE+c)*16 +: 16];
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Plain matrix product; the wide sum is reduced modulo 2**WIDTH once at the end.
  task automatic model_product();
    for (int i = 0; i < CHUNK_SIZE; i++)
      for (int j = 0; j < CHUNK_SIZE; j++) begin
        longint s = 0;
        for (int k = 0; k < PIM_UNIT_CAPACITY; k++)
          s += longint'(bus.matrixA[i][k]) * longint'(bus.matrixB[k][j]);
        exp_res[i*CHUNK_SIZE+j] = int'(s % (longint'(1) << WIDTH));
      end
  endtask

  task automatic cycle(input bit v, input bit r);
    bit exp_busy, exp_rv;
    bus.valid = v;
    rst       = r;
    @(negedge clk);
    exp_busy = pend && (t >= acc_t + 1) && (t <= acc_t + N);
    exp_rv   = pend && (t == acc_t + N + 1);
    check("busy", 32'(bus.busy), 32'(exp_busy));
    check("result_valid", 32'(bus.result_valid), 32'(exp_rv));
    if (exp_rv)
      for (int e = 0; e < ELS; e++) check($sformatf("result[%0d]", e), 32'(bus.result[e]), exp_res[e]);
    if (zero_chk) begin
      for (int e = 0; e < ELS; e++) check($sformatf("rst_result[%0d]", e), 32'(bus.result[e]), 0);
      zero_chk = 1'b0;
    end
    if (r) begin
      pend     = 1'b0;
      zero_chk = 1'b1;
    end else if (v && !exp_busy) begin
      pend  = 1'b1;
      acc_t = t;
      model_product();
    end else if (exp_rv) begin
      pend = 1'b0;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  localparam logic [63:0] A1  = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] B1  = {16'd8, 16'd7, 16'd6, 16'd5};
  localparam logic [63:0] EYE = {16'd1, 16'd0, 16'd0, 16'd1};
  localparam logic [63:0] ONES = {64{1'b1}};

  initial begin
    rst       = 1'b1;
    bus.valid = 1'b0;
    load_ops('0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_result_valid", 32'(bus.result_valid), 0);
    for (int e = 0; e < ELS; e++) check($sformatf("reset_result[%0d]", e), 32'(bus.result[e]), 0);

    // Basic product with fixed latency, then hold of the completed tile.
    load_ops(A1, B1);
    cycle(1, 0);
    repeat (10) cycle(0, 0);
    check("hold[0]", 32'(bus.result[0]), 19);
    check("hold[1]", 32'(bus.result[1]), 22);
    check("hold[2]", 32'(bus.result[2]), 43);
    check("hold[3]", 32'(bus.result[3]), 50);

    // Re-pulse of valid mid-computation is ignored.
    load_ops(A1, B1);
    cycle(1, 0);
    repeat (3) cycle(0, 0);
    load_ops(rand64(), rand64());
    cycle(1, 0);
    repeat (6) cycle(0, 0);

    // Back-to-back request accepted in the DONE cycle.
    load_ops(A1, B1);
    cycle(1, 0);
    repeat (8) cycle(0, 0);
    load_ops(EYE, B1);
    cycle(1, 0);
    repeat (10) cycle(0, 0);

    // Reset mid-computation aborts, then a fresh request completes normally.
    load_ops(rand64(), rand64());
    cycle(1, 0);
    repeat (4) cycle(0, 0);
    cycle(0, 1);
    cycle(0, 0);
    load_ops(A1, B1);
    cycle(1, 0);
    repeat (10) cycle(0, 0);

    // Modulo wrap with all-ones operands, then an all-zero left operand.
    load_ops(ONES, ONES);
    cycle(1, 0);
    repeat (10) cycle(0, 0);
    load_ops('0, rand64());
    cycle(1, 0);
    repeat (10) cycle(0, 0);

    // Random traffic: frequent valid pulses, occasional reset.
    repeat (400) begin
      bit v, r;
      v = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 60) == 0);
      if (v) load_ops(rand64(), rand64());
      cycle(v, r);
    end
    repeat (12) cycle(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pim_tile_engine.md
PIM_TILE_ENGINE -- requirements
Module: pim_tile_engine

Interface
REQ-001 SHALL take parameter ID, default 0: engine index, used for debug display only.
REQ-002 SHALL take WIDTH, CHUNK_SIZE and PIM_UNIT_CAPACITY from the shared types package (no local overrides).
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 valid  input  1  request strobe; operands valid in the same cycle.
REQ-006 matrixA  input  WIDTH x [CHUNK_SIZE][PIM_UNIT_CAPACITY]  left operand tile.
REQ-007 matrixB  input  WIDTH x [PIM_UNIT_CAPACITY][CHUNK_SIZE]  right operand tile.
REQ-008 result  output  WIDTH x [CHUNK_SIZE**2]  row-major product tile, result[i*CHUNK_SIZE+j].
REQ-009 result_valid  output  1  one-cycle completion pulse.
REQ-010 busy  output  1  high while a request is held or being computed.

Function
REQ-011 SHALL implement FSM states IDLE, COMPUTE, DONE.
REQ-012 IDLE: valid=1 -> capture matrixA/matrixB into internal operand registers, clear the accumulator, zero the i/j/k counters, and go to COMPUTE.
REQ-013 COMPUTE SHALL perform exactly one MAC per cycle: acc += opA[i][k]*opB[k][j], with k innermost, then j, then i.
REQ-014 When k reaches PIM_UNIT_CAPACITY-1, the final sum SHALL be written to result[i*CHUNK_SIZE+j] and acc cleared for the next element.
REQ-015 After the MAC for i=j=CHUNK_SIZE-1, k=PIM_UNIT_CAPACITY-1, the FSM SHALL go to DONE.
REQ-016 DONE SHALL assert result_valid for exactly one cycle with every result element final in that cycle.
REQ-017 DONE: valid=1 -> accepted as in IDLE (back-to-back operation); otherwise -> IDLE.
REQ-018 Latency: with valid accepted in cycle 0 and N=CHUNK_SIZE**2*PIM_UNIT_CAPACITY, COMPUTE SHALL occupy cycles 1..N and result_valid SHALL be high in cycle N+1.
REQ-019 valid asserted in COMPUTE SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-020 busy SHALL be 1 in COMPUTE and 0 in IDLE and DONE.
REQ-021 result SHALL hold its last completed value until a later operation overwrites it element by element; the caller samples result only while result_valid=1.
REQ-022 Arithmetic SHALL be unsigned and modulo 2**WIDTH: each product truncated to WIDTH bits, each accumulate wrapping, no saturation and no overflow flag.
REQ-023 Latency SHALL be fixed regardless of operand values, with no zero-skipping; sparsity skipping belongs to the controller.
REQ-024 Counters SHALL be $clog2-sized and each SHALL wrap to 0 after reaching its maximum index.

Reset
REQ-025 rst=1 SHALL force state IDLE, clear the i/j/k counters and acc, set result_valid=0 and busy=0, and set every result element to 0.
REQ-026 rst asserted mid-COMPUTE SHALL abort the operation with no result_valid pulse; the first edge after release SHALL see IDLE.
REQ-027 rst SHALL take priority over a simultaneous valid.

Structure
REQ-028 WIDTH, CHUNK_SIZE and PIM_UNIT_CAPACITY SHALL live in the shared types package, together with the engine state enum (pim_eng_state_t).
REQ-029 The multiply-accumulate datapath SHALL be a single sub-module pim_mac (inputs a, b, clear, en; output acc), instantiated once.
REQ-030 The block SHALL be a drop-in responder for the controller's valid/matrixA/matrixB -> result/result_valid port set.

Verification (WIDTH=16, CHUNK_SIZE=2, PIM_UNIT_CAPACITY=2, N=8)
REQ-031 A=[[1,2],[3,4]], B=[[5,6],[7,8]], valid in cycle 0 -> result_valid only in cycle 9, result=[19,22,43,50], busy high in cycles 1-8.
REQ-032 All A and B elements = 0xFFFF -> every result element = 0x0002 (modulo wrap).
REQ-033 valid re-pulsed in cycle 4 with different operands -> cycle-9 result unchanged at [19,22,43,50], and no second result_valid pulse.
REQ-034 valid in DONE cycle 9 with A=identity, B=[[5,6],[7,8]] -> second result_valid in cycle 18, result=[5,6,7,8].
REQ-035 rst in cycle 5 -> no result_valid, result all 0, busy=0; a fresh valid afterwards completes with normal latency.
REQ-036 A all zero, any B -> result all 0 with result_valid still in cycle 9.
